// File: rtl/ppu_vga_frame_buf_pkg.sv
// Shared types and default geometry for the PPU-to-VGA frame buffer.
// Holds the back-bank FSM encoding and the helper that centres the scaled image.
package ppu_vga_frame_buf_pkg;

    typedef enum logic {
        FB_FILL    = 1'b0,
        FB_PENDING = 1'b1
    } fb_state_e;

    localparam int              DEF_SRC_W      = 256;
    localparam int              DEF_SRC_H      = 240;
    localparam int              DEF_PIX_W      = 8;
    localparam int              DEF_DST_W      = 640;
    localparam int              DEF_DST_H      = 480;
    localparam int              DEF_SCALE      = 1;
    localparam logic [7:0]      DEF_BORDER_IDX = 8'h0F;

    // Raster offsets are held at 11 bits so a subtract that underflows lands far outside the image.
    localparam int              OFF_W          = 11;

    function automatic logic [OFF_W-1:0] centre_offset(input int dst, input int src, input int shift);
        return OFF_W'((dst - (src << shift)) / 2);
    endfunction

endpackage

// File: rtl/ppu_vga_frame_buf_bank_ram.sv
// Simple dual-port pixel store: one write port, one registered read port.
// Latency: read data appears one cycle after rd_addr. Backpressure: none, always accepts.
// Contents are deliberately not reset so the array maps onto block RAM.
module ppu_vga_frame_buf_bank_ram
    import ppu_vga_frame_buf_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = DEF_PIX_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_q
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_q <= mem[rd_addr];
    end

endmodule

// File: rtl/ppu_vga_frame_buf.sv
// Double-buffered PPU frame store with centred integer up-scaling onto the VGA raster.
// Latency: rd_data follows rd_row/rd_col by 2 cycles, one pixel per cycle, never stalls.
// Backpressure: wr_ready drops once a frame is complete until the VGA side takes it at frame end.
module ppu_vga_frame_buf
    import ppu_vga_frame_buf_pkg::*;
#(
    parameter int               SRC_W       = DEF_SRC_W,
    parameter int               SRC_H       = DEF_SRC_H,
    parameter int               PIX_W       = DEF_PIX_W,
    parameter int               DST_W       = DEF_DST_W,
    parameter int               DST_H       = DEF_DST_H,
    parameter int               SCALE_SHIFT = DEF_SCALE,
    parameter int               DOUBLE_BUF  = 1,
    parameter logic [PIX_W-1:0] BORDER_IDX  = PIX_W'(DEF_BORDER_IDX)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [8:0]       wr_row,
    input  logic [8:0]       wr_col,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             wr_en,
    input  logic             wr_frame_done,
    output logic             wr_ready,
    input  logic [9:0]       rd_row,
    input  logic [9:0]       rd_col,
    input  logic             vga_frame_end,
    output logic [PIX_W-1:0] rd_data,
    output logic [15:0]      frame_count,
    output logic             overrun
);

    localparam int COL_W   = $clog2(SRC_W);
    localparam int ROW_W   = $clog2(SRC_H);
    localparam int FULL_AW = 1 + ROW_W + COL_W;
    localparam int RAM_AW  = ((DOUBLE_BUF != 0) ? 1 : 0) + ROW_W + COL_W;

    localparam logic [OFF_W-1:0] H_OFF    = centre_offset(DST_W, SRC_W, SCALE_SHIFT);
    localparam logic [OFF_W-1:0] V_OFF    = centre_offset(DST_H, SRC_H, SCALE_SHIFT);
    localparam logic [OFF_W-1:0] SCALED_W = OFF_W'(SRC_W << SCALE_SHIFT);
    localparam logic [OFF_W-1:0] SCALED_H = OFF_W'(SRC_H << SCALE_SHIFT);
    localparam logic [8:0]       SRC_W_LIM = 9'(SRC_W);
    localparam logic [8:0]       SRC_H_LIM = 9'(SRC_H);

    fb_state_e          state;
    fb_state_e          state_nxt;
    logic               swap;
    logic               overrun_set;
    logic               front;
    logic               back;
    logic               wr_accept;
    logic [FULL_AW-1:0] wr_addr_full;

    logic [OFF_W-1:0]   col_off;
    logic [OFF_W-1:0]   row_off;
    logic [OFF_W-1:0]   src_col;
    logic [OFF_W-1:0]   src_row;
    logic               inside_c;
    logic               rd_bank;
    logic [FULL_AW-1:0] rd_addr_full;
    logic [RAM_AW-1:0]  rd_addr_s1;
    logic               inside_s1;
    logic               inside_s2;
    logic [PIX_W-1:0]   ram_q;
    logic               unused_ok;

    // In single-buffer builds both roles collapse onto bank 0.
    assign back    = (DOUBLE_BUF != 0) ? ~front : 1'b0;
    assign rd_bank = (DOUBLE_BUF != 0) ? front  : 1'b0;

    assign wr_accept    = wr_en & wr_ready & (wr_row < SRC_H_LIM) & (wr_col < SRC_W_LIM);
    assign wr_addr_full = {back, wr_row[ROW_W-1:0], wr_col[COL_W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FB_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        swap        = 1'b0;
        overrun_set = 1'b0;
        wr_ready    = (state == FB_FILL);
        case (state)
            FB_FILL: begin
                if (wr_frame_done) begin
                    if (vga_frame_end) begin
                        swap = 1'b1;
                    end else begin
                        state_nxt = FB_PENDING;
                    end
                end
            end
            FB_PENDING: begin
                overrun_set = wr_frame_done;
                if (vga_frame_end) begin
                    swap      = 1'b1;
                    state_nxt = FB_FILL;
                end
            end
            default: state_nxt = FB_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front       <= 1'b0;
            frame_count <= '0;
            overrun     <= 1'b0;
        end else begin
            if (swap) begin
                front       <= (DOUBLE_BUF != 0) ? ~front : 1'b0;
                frame_count <= frame_count + 16'd1;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end
        end
    end

    // Anything left of or above the image wraps to a huge offset and fails the range test.
    assign col_off  = {1'b0, rd_col} - H_OFF;
    assign row_off  = {1'b0, rd_row} - V_OFF;
    assign inside_c = (col_off < SCALED_W) && (row_off < SCALED_H);
    assign src_col  = col_off >> SCALE_SHIFT;
    assign src_row  = row_off >> SCALE_SHIFT;
    assign rd_addr_full = {rd_bank, src_row[ROW_W-1:0], src_col[COL_W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_s1 <= '0;
            inside_s1  <= 1'b0;
            inside_s2  <= 1'b0;
        end else begin
            rd_addr_s1 <= rd_addr_full[RAM_AW-1:0];
            inside_s1  <= inside_c;
            inside_s2  <= inside_s1;
        end
    end

    ppu_vga_frame_buf_bank_ram #(
        .ADDR_W (RAM_AW),
        .DATA_W (PIX_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_addr_full[RAM_AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_addr_s1),
        .rd_q    (ram_q)
    );

    assign rd_data = inside_s2 ? ram_q : BORDER_IDX;

    assign unused_ok = ^{wr_row, wr_col, col_off, row_off, src_col, src_row, wr_addr_full, rd_addr_full};

endmodule

// File: tb/tb_ppu_vga_frame_buf.sv
// Randomised bench for ppu_vga_frame_buf against a frame-level reference model.
// A second instance built single-buffered covers the legacy mode.
module tb_ppu_vga_frame_buf;

    localparam int         SRC_W  = 256;
    localparam int         SRC_H  = 240;
    localparam int         DST_W  = 640;
    localparam int         DST_H  = 480;
    localparam int         SCALE  = 2;
    localparam logic [7:0] BORDER = 8'h0F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  wr_row = '0;
    logic [8:0]  wr_col = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_en = 1'b0;
    logic        wr_frame_done = 1'b0;
    logic        vga_frame_end = 1'b0;
    logic [9:0]  rd_row = '0;
    logic [9:0]  rd_col = '0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic [15:0] frame_count;
    logic        overrun;

    logic [8:0]  sb_wr_row = '0;
    logic [8:0]  sb_wr_col = '0;
    logic [7:0]  sb_wr_data = '0;
    logic        sb_wr_en = 1'b0;
    logic        sb_done = 1'b0;
    logic        sb_fend = 1'b0;
    logic        sb_wr_ready;
    logic [7:0]  sb_rd_data;
    logic [15:0] sb_frame_count;
    logic        sb_overrun;

    always #20 clk = ~clk;

    ppu_vga_frame_buf #(.DOUBLE_BUF(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_en(wr_en),
        .wr_frame_done(wr_frame_done), .wr_ready(wr_ready),
        .rd_row(rd_row), .rd_col(rd_col), .vga_frame_end(vga_frame_end),
        .rd_data(rd_data), .frame_count(frame_count), .overrun(overrun)
    );

    ppu_vga_frame_buf #(.DOUBLE_BUF(0)) u_sb (
        .clk(clk), .rst_n(rst_n),
        .wr_row(sb_wr_row), .wr_col(sb_wr_col), .wr_data(sb_wr_data), .wr_en(sb_wr_en),
        .wr_frame_done(sb_done), .wr_ready(sb_wr_ready),
        .rd_row(rd_row), .rd_col(rd_col), .vga_frame_end(sb_fend),
        .rd_data(sb_rd_data), .frame_count(sb_frame_count), .overrun(sb_overrun)
    );

    // Reference model: two whole source frames plus which one is on screen.
    logic [7:0] m_mem [2][SRC_H][SRC_W];
    int m_front   = 0;
    int m_pending = 0;
    int m_count   = 0;
    int m_overrun = 0;

    int n_cmp = 0;
    int n_bad = 0;

    int         rq_row[$];
    int         rq_col[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    function automatic logic [7:0] m_expect(input int bank, input int row, input int col);
        int x;
        int y;
        x = col - (DST_W - SRC_W * SCALE) / 2;
        y = row - (DST_H - SRC_H * SCALE) / 2;
        if (x < 0 || x >= SRC_W * SCALE || y < 0 || y >= SRC_H * SCALE) return BORDER;
        return m_mem[bank][y / SCALE][x / SCALE];
    endfunction

    function automatic int src_row_of(input int k);
        return (k < 8) ? k : 224 + k;
    endfunction

    task automatic new_reads();
        rq_row.delete();
        rq_col.delete();
        got_q.delete();
        exp_q.delete();
    endtask

    // One clock of write-side stimulus; the model applies the same cycle's effect.
    task automatic cycle(input logic we, input int row, input int col, input logic [7:0] d,
                         input logic done, input logic fend);
        wr_en = we; wr_row = 9'(row); wr_col = 9'(col); wr_data = d;
        wr_frame_done = done; vga_frame_end = fend;
        if (we && m_pending == 0 && row < SRC_H && col < SRC_W) m_mem[1 - m_front][row][col] = d;
        if (fend && (m_pending != 0 || done)) begin
            if (m_pending != 0 && done) m_overrun = 1;
            m_front   = 1 - m_front;
            m_count   = (m_count + 1) % 65536;
            m_pending = 0;
        end else if (done) begin
            if (m_pending != 0) m_overrun = 1;
            else m_pending = 1;
        end
        @(negedge clk);
        wr_en = 1'b0; wr_frame_done = 1'b0; vga_frame_end = 1'b0;
    endtask

    task automatic fill_frame(input int mode);
        logic [7:0] d;
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < SRC_W; c++) begin
                d = (mode == 0) ? 8'(c) : (mode == 1) ? 8'h22 : ~8'(c);
                cycle(1'b1, src_row_of(k), c, d, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic queue_random(input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            k = int'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) rq_row.push_back(int'($urandom_range(480, 1023)));
            else rq_row.push_back(2 * src_row_of(k) + int'($urandom_range(0, 1)));
            rq_col.push_back(int'($urandom_range(0, 1023)));
        end
    endtask

    task automatic run_reads();
        int n;
        n = rq_row.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i >= 2) got_q.push_back(rd_data);
            if (i < n) begin
                rd_row = 10'(rq_row[i]);
                rd_col = 10'(rq_col[i]);
                exp_q.push_back(m_expect(m_front, rq_row[i], rq_col[i]));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        n_cmp++; if (rd_data !== BORDER) begin n_bad++; $display("FAIL reset_rd_data got %h want %h", rd_data, BORDER); end
        n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", frame_count); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b want 0", overrun); end
        rst_n = 1'b1;
        @(negedge clk);
        cycle(1'b1, 1, 1, 8'h33, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (wr_ready !== (m_pending == 0)) begin n_bad++; $display("FAIL pre_reset_ready got %b want %b", wr_ready, m_pending == 0); end
        cycle(1'b0, 0, 0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (overrun !== (m_overrun != 0)) begin n_bad++; $display("FAIL pre_reset_overrun got %b want %b", overrun, m_overrun != 0); end
        rd_row = 10'd0; rd_col = 10'd64;
        wr_en = 1'b1; wr_row = 9'd2; wr_col = 9'd2; wr_data = 8'h44;
        #5;
        rst_n = 1'b0; wr_en = 1'b0;
        m_front = 0; m_pending = 0; m_count = 0; m_overrun = 0;
        #1;
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_wr_ready got %b want 1", wr_ready); end
        n_cmp++; if (rd_data !== BORDER) begin n_bad++; $display("FAIL midreset_rd_data got %h want %h", rd_data, BORDER); end
        n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL midreset_count got %0d want 0", frame_count); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL midreset_overrun got %b want 0", overrun); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill_swap();
        fill_frame(0);
        cycle(1'b0, 0, 0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (wr_ready !== (m_pending == 0)) begin n_bad++; $display("FAIL fill_pending_ready got %b want %b", wr_ready, m_pending == 0); end
        cycle(1'b0, 0, 0, 8'h00, 1'b0, 1'b1);
        n_cmp++; if (frame_count !== 16'(m_count)) begin n_bad++; $display("FAIL fill_count got %0d want %0d", frame_count, m_count); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_after got %b want 1", wr_ready); end
        new_reads();
        for (int c = 64; c < 68; c++) begin rq_row.push_back(0); rq_col.push_back(c); end
        queue_random(40);
        run_reads();
        for (int i = 0; i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL fill_read row=%0d col=%0d got %h want %h", rq_row[i], rq_col[i], got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_border();
        new_reads();
        rq_row = '{0, 0, 0, 0, 0, 479, 480, 1023};
        rq_col = '{0, 63, 575, 576, 639, 100, 100, 64};
        run_reads();
        for (int i = 0; i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL border row=%0d col=%0d got %h want %h", rq_row[i], rq_col[i], got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_tear_free();
        fill_frame(1);
        new_reads();
        queue_random(30);
        run_reads();
        for (int i = 0; i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL tear_old row=%0d col=%0d got %h want %h", rq_row[i], rq_col[i], got_q[i], exp_q[i]); end
        end
        cycle(1'b0, 0, 0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 8'h00, 1'b0, 1'b1);
        n_cmp++; if (frame_count !== 16'(m_count)) begin n_bad++; $display("FAIL tear_count got %0d want %0d", frame_count, m_count); end
        new_reads();
        queue_random(30);
        run_reads();
        for (int i = 0; i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL tear_new row=%0d col=%0d got %h want %h", rq_row[i], rq_col[i], got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overrun();
        cycle(1'b0, 0, 0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (overrun !== (m_overrun != 0)) begin n_bad++; $display("FAIL overrun_flag got %b want %b", overrun, m_overrun != 0); end
        n_cmp++; if (wr_ready !== (m_pending == 0)) begin n_bad++; $display("FAIL overrun_ready got %b want %b", wr_ready, m_pending == 0); end
        cycle(1'b0, 0, 0, 8'h00, 1'b0, 1'b1);
        n_cmp++; if (frame_count !== 16'(m_count)) begin n_bad++; $display("FAIL overrun_count got %0d want %0d", frame_count, m_count); end
        n_cmp++; if (overrun !== (m_overrun != 0)) begin n_bad++; $display("FAIL overrun_sticky got %b want %b", overrun, m_overrun != 0); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_old;
        logic [7:0] exp_new;
        fill_frame(2);
        rd_row = 10'd6; rd_col = 10'd84;
        exp_old = m_expect(m_front, 6, 84);
        cycle(1'b1, 3, 10, 8'h5A, 1'b1, 1'b1);
        exp_new = m_expect(m_front, 6, 84);
        n_cmp++; if (wr_ready !== (m_pending == 0)) begin n_bad++; $display("FAIL simul_ready got %b want %b", wr_ready, m_pending == 0); end
        n_cmp++; if (frame_count !== 16'(m_count)) begin n_bad++; $display("FAIL simul_count got %0d want %0d", frame_count, m_count); end
        @(negedge clk);
        n_cmp++; if (rd_data !== exp_old) begin n_bad++; $display("FAIL simul_inflight got %h want %h", rd_data, exp_old); end
        @(negedge clk);
        n_cmp++; if (rd_data !== exp_new) begin n_bad++; $display("FAIL simul_swapcycle_write got %h want %h", rd_data, exp_new); end
        new_reads();
        queue_random(30);
        run_reads();
        for (int i = 0; i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL simul_read row=%0d col=%0d got %h want %h", rq_row[i], rq_col[i], got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_guards();
        cycle(1'b1, 240, 9, 8'hE1, 1'b0, 1'b0);
        cycle(1'b1, 259, 5, 8'hE2, 1'b0, 1'b0);
        cycle(1'b1, 3, 260, 8'hE3, 1'b0, 1'b0);
        cycle(1'b1, 300, 300, 8'hE4, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (wr_ready !== (m_pending == 0)) begin n_bad++; $display("FAIL guard_ready got %b want %b", wr_ready, m_pending == 0); end
        cycle(1'b1, 4, 7, 8'hE5, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 8'h00, 1'b0, 1'b1);
        new_reads();
        rq_row = '{6, 6, 8, 7};
        rq_col = '{74, 72, 78, 83};
        run_reads();
        for (int i = 0; i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL guard_read row=%0d col=%0d got %h want %h", rq_row[i], rq_col[i], got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_single_buf();
        int         c[4];
        logic [7:0] d[4];
        for (int i = 0; i < 4; i++) begin
            c[i] = i * 60 + int'($urandom_range(0, 50));
            d[i] = 8'($urandom);
            sb_wr_en = 1'b1; sb_wr_row = 9'd5; sb_wr_col = 9'(c[i]); sb_wr_data = d[i];
            @(negedge clk);
            sb_wr_en = 1'b0;
            rd_row = 10'd10; rd_col = 10'(64 + 2 * c[i]);
            repeat (2) @(negedge clk);
            n_cmp++; if (sb_rd_data !== d[i]) begin n_bad++; $display("FAIL sb_direct col=%0d got %h want %h", c[i], sb_rd_data, d[i]); end
        end
        sb_done = 1'b1;
        @(negedge clk);
        sb_done = 1'b0;
        n_cmp++; if (sb_wr_ready !== 1'b0) begin n_bad++; $display("FAIL sb_ready_done got %b want 0", sb_wr_ready); end
        sb_wr_en = 1'b1; sb_wr_col = 9'(c[0]); sb_wr_data = ~d[0];
        @(negedge clk);
        sb_wr_en = 1'b0;
        rd_col = 10'(64 + 2 * c[0]);
        repeat (2) @(negedge clk);
        n_cmp++; if (sb_rd_data !== d[0]) begin n_bad++; $display("FAIL sb_blocked_write got %h want %h", sb_rd_data, d[0]); end
        sb_fend = 1'b1;
        @(negedge clk);
        sb_fend = 1'b0;
        n_cmp++; if (sb_frame_count !== 16'd1) begin n_bad++; $display("FAIL sb_count got %0d want 1", sb_frame_count); end
        n_cmp++; if (sb_wr_ready !== 1'b1) begin n_bad++; $display("FAIL sb_ready_after got %b want 1", sb_wr_ready); end
        sb_wr_en = 1'b1; sb_wr_data = 8'h77;
        @(negedge clk);
        sb_wr_en = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (sb_rd_data !== 8'h77) begin n_bad++; $display("FAIL sb_rewrite got %h want 77", sb_rd_data); end
    endtask

    initial begin
        test_reset();
        test_fill_swap();
        test_border();
        test_tear_free();
        test_overrun();
        test_simultaneous();
        test_guards();
        test_single_buf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
